pool_img_loader: RTL and testbench

Memory-read front end for the pooling stage. On `start`, fetches `img_count` square images of `img_size` x `img_size` 16-bit pixels, stored contiguously in feature-map memory from `base_addr`. Pixels go out as a row-major valid/ready stream tagged with pixel index and last-pixel / last-image flags. Sits between the feature-map RAM and the pool stage, and replaces that stage's bulk image-load path.

---
 rtl/pool_img_loader.sv | 171 +++++++++++++++++
 tb/tb_pool_img_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_img_loader.sv
// Memory-read front end for the pooling stage: fetches img_count square images
// from feature-map memory and streams them row-major with pixel/image tags.
module pool_img_loader #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_W     = 16,
  parameter int MAX_IMG    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [15:0]          img_size,
  input  logic [15:0]          img_count,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_SIZE-1:0] mem_rd_data,
  input  logic                 mem_rd_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [15:0]          out_pix_idx,
  output logic                 out_last_pix,
  output logic                 out_last_img,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      MAX_C   = 16'(MAX_IMG);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [31:0]         total_q, total_d;
  logic [31:0]         issued_q, issued_d;
  logic [15:0]         last_pix_q, last_pix_d;
  logic [15:0]         last_img_q, last_img_d;
  logic [15:0]         pix_q, pix_d;
  logic [15:0]         img_q, img_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    fcnt_q, fcnt_d;
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [DATA_SIZE-1:0] fifo_q [FIFO_DEPTH];

  logic                push, pop, issue, credit_ok;
  logic [CNT_W:0]      used;
  logic [31:0]         size32, area32;

  // Data arriving with no read outstanding (e.g. after a reset) is dropped.
  assign push      = mem_rd_valid && (outst_q != '0);
  assign out_valid = (fcnt_q != '0);
  assign pop       = out_valid && out_ready;
  // A slot freed by this cycle's accept may be re-requested immediately.
  assign used      = {1'b0, outst_q} + {1'b0, fcnt_q} - {{CNT_W{1'b0}}, pop};
  assign credit_ok = (used < {1'b0, DEPTH_C});
  assign issue     = (state_q == REQ) && (issued_q != total_q) && credit_ok;
  assign size32    = {16'b0, img_size};
  assign area32    = size32 * size32;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    total_d    = total_q;
    issued_d   = issued_q;
    last_pix_d = last_pix_q;
    last_img_d = last_img_q;
    pix_d      = pix_q;
    img_d      = img_q;
    err_d      = err_q;
    outst_d    = outst_q + CNT_W'(issue) - CNT_W'(push);
    fcnt_d     = fcnt_q + CNT_W'(push) - CNT_W'(pop);

    if (pop) begin
      if (pix_q == last_pix_q) begin
        pix_d = '0;
        img_d = img_q + 16'd1;
      end else begin
        pix_d = pix_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          rd_addr_d  = base_addr;
          issued_d   = '0;
          pix_d      = '0;
          img_d      = '0;
          total_d    = area32 * {16'b0, img_count};
          last_pix_d = area32[15:0] - 16'd1;
          last_img_d = img_count - 16'd1;
          if (img_size == '0 || img_count == '0) begin
            state_d = FIN;
          end else if (img_size > MAX_C) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          issued_d  = issued_q + 32'd1;
          if (issued_q == total_q - 32'd1) state_d = DRAIN;
        end
      end
      // Looking at next-cycle occupancy lets done follow the last accept directly.
      DRAIN: begin
        if (outst_d == '0 && fcnt_d == '0) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      last_pix_q <= '0;
      last_img_q <= '0;
      pix_q      <= '0;
      img_q      <= '0;
      err_q      <= 1'b0;
      outst_q    <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      last_pix_q <= last_pix_d;
      last_img_q <= last_img_d;
      pix_q      <= pix_d;
      img_q      <= img_d;
      err_q      <= err_d;
      outst_q    <= outst_d;
      fcnt_q     <= fcnt_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= mem_rd_data;
  end

  assign mem_rd_en    = issue;
  assign mem_addr     = issue ? rd_addr_q : '0;
  assign out_data     = out_valid ? fifo_q[rptr_q] : '0;
  assign out_pix_idx  = out_valid ? pix_q : '0;
  assign out_last_pix = out_valid && (pix_q == last_pix_q);
  assign out_last_img = out_valid && (img_q == last_img_q);
  assign busy         = (state_q == REQ) || (state_q == DRAIN);
  assign done         = (state_q == FIN);
  assign err          = err_q;

endmodule

// File: tb/tb_pool_img_loader.sv
// Scoreboard bench for pool_img_loader: expected beats and read addresses are
// queued at stimulus time and checked by an independent negedge monitor.
module tb_pool_img_loader;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] base_addr, img_size, img_count;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data, out_pix_idx;
  logic        out_last_pix, out_last_img, busy, done, err;

  always #5 clk = ~clk;

  pool_img_loader #(
    .DATA_SIZE(16), .ADDR_W(16), .MAX_IMG(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .img_size(img_size), .img_count(img_count), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pix_idx(out_pix_idx), .out_last_pix(out_last_pix),
    .out_last_img(out_last_img), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] idx;
    logic        lp;
    logic        li;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] addr_q[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, acc_total = 0, rd_total = 0, inflight = 0;

  // Memory model: mem[a] = a, returned after (lat_m1 + 1) cycles in order.
  logic [3:0]  pv = '0;
  logic [15:0] pd [4];
  logic [1:0]  lat_m1 = 2'd0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_rd_en};
    pd[0] <= mem_addr;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign mem_rd_valid = pv[lat_m1];
  assign mem_rd_data  = pd[lat_m1];

  logic rdy_mode = 1'b0;
  initial begin : ready_driver
    int rcnt;
    rcnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (!rdy_mode) out_ready = 1'b1;
      else begin
        out_ready = (rcnt == 0);
        rcnt = (rcnt + 1) % 4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks read addresses, output beats, stall hold and credit bound.
  logic        hold_v = 1'b0;
  logic [15:0] hold_d, hold_i;
  always @(negedge clk) begin
    if (reset) begin
      inflight = 0;
      hold_v   = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_total++;
        inflight++;
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: got addr 0x%0h expected no read", mem_addr);
        end else begin
          chk("mem_addr", {16'b0, mem_addr}, {16'b0, addr_q.pop_front()});
        end
      end
      if (hold_v) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_data", {16'b0, out_data}, {16'b0, hold_d});
        chk("stall_idx", {16'b0, out_pix_idx}, {16'b0, hold_i});
      end
      if (out_valid && out_ready) begin
        acc_total++;
        inflight--;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got data 0x%0h expected none", out_data);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("out_data", {16'b0, out_data}, {16'b0, b.d});
          chk("out_pix_idx", {16'b0, out_pix_idx}, {16'b0, b.idx});
          chk("out_last_pix", {31'b0, out_last_pix}, {31'b0, b.lp});
          chk("out_last_img", {31'b0, out_last_img}, {31'b0, b.li});
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_i = out_pix_idx;
      chk("credit_bound", {31'b0, (inflight <= 4)}, 32'd1);
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_img(input logic [15:0] base, input int size, input int count);
    beat_t b;
    logic [15:0] a;
    for (int i = 0; i < count; i++) begin
      for (int p = 0; p < size * size; p++) begin
        a     = base + 16'(i * size * size + p);
        b.d   = a;
        b.idx = 16'(p);
        b.lp  = (p == size * size - 1);
        b.li  = (i == count - 1);
        exp_q.push_back(b);
        addr_q.push_back(a);
      end
    end
  endtask

  task automatic do_start(input logic [15:0] base, input int size, input int count);
    base_addr = base;
    img_size  = 16'(size);
    img_count = 16'(count);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound, output int cyc);
    logic got;
    got = 1'b0;
    cyc = 0;
    while (cyc < bound && !got) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
    end
    chk(name, {31'b0, got}, 32'd1);
  endtask

  task automatic end_checks(input string name, input int d0);
    step();
    chk({name, "_done_low"}, {31'b0, done}, 32'd0);
    chk({name, "_busy_low"}, {31'b0, busy}, 32'd0);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int cyc, d0, r0, a0;
    reset = 1'b1; start = 1'b0;
    base_addr = '0; img_size = '0; img_count = '0;
    repeat (3) step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'd0);
    reset = 1'b0;
    step();

    // 1: two 2x2 images, latency 1, always ready
    push_img(16'h0100, 2, 2);
    d0 = done_cnt;
    do_start(16'h0100, 2, 2);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_first_rd", {31'b0, mem_rd_en}, 32'd1);
    wait_done("t1_done_seen", 50, cyc);
    chk("t1_latency", 32'(cyc), 32'd11);
    end_checks("t1", d0);

    // 2: one 4x4 image, latency 3, ready 1-on/3-off
    lat_m1 = 2'd2; rdy_mode = 1'b1;
    push_img(16'h0300, 4, 1);
    d0 = done_cnt;
    do_start(16'h0300, 4, 1);
    wait_done("t2_done_seen", 400, cyc);
    end_checks("t2", d0);
    rdy_mode = 1'b0; lat_m1 = 2'd0;
    repeat (4) step();

    // 3: address wrap
    push_img(16'hFFFE, 2, 1);
    d0 = done_cnt;
    do_start(16'hFFFE, 2, 1);
    wait_done("t3_done_seen", 50, cyc);
    end_checks("t3", d0);

    // 4: zero count, then zero size
    d0 = done_cnt; r0 = rd_total;
    do_start(16'h0000, 4, 0);
    wait_done("t4a_done_seen", 5, cyc);
    chk("t4a_done_lat", {31'b0, (cyc <= 2)}, 32'd1);
    chk("t4a_err", {31'b0, err}, 32'd0);
    end_checks("t4a", d0);
    chk("t4a_no_reads", 32'(rd_total - r0), 32'd0);
    d0 = done_cnt; r0 = rd_total;
    do_start(16'h0000, 0, 3);
    wait_done("t4b_done_seen", 5, cyc);
    chk("t4b_done_lat", {31'b0, (cyc <= 2)}, 32'd1);
    chk("t4b_err", {31'b0, err}, 32'd0);
    end_checks("t4b", d0);
    chk("t4b_no_reads", 32'(rd_total - r0), 32'd0);

    // 5: oversize image sets err; next valid start clears it
    d0 = done_cnt; r0 = rd_total;
    do_start(16'h0000, 33, 1);
    wait_done("t5_done_seen", 5, cyc);
    chk("t5_err_set", {31'b0, err}, 32'd1);
    end_checks("t5", d0);
    chk("t5_no_reads", 32'(rd_total - r0), 32'd0);
    chk("t5_err_sticky", {31'b0, err}, 32'd1);
    push_img(16'h0200, 1, 1);
    d0 = done_cnt;
    do_start(16'h0200, 1, 1);
    chk("t5_err_cleared", {31'b0, err}, 32'd0);
    wait_done("t5b_done_seen", 20, cyc);
    end_checks("t5b", d0);

    // 6: reset mid-stream with reads in flight, then restart
    lat_m1 = 2'd2;
    push_img(16'h0000, 4, 1);
    a0 = acc_total;
    do_start(16'h0000, 4, 1);
    for (int k = 0; k < 200 && (acc_total - a0) < 3; k++) step();
    chk("t6_reached3", {31'b0, ((acc_total - a0) >= 3)}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    step();
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_data", {16'b0, out_data}, 32'd0);
    chk("t6_rst_idx", {16'b0, out_pix_idx}, 32'd0);
    chk("t6_rst_flags", {30'b0, out_last_pix, out_last_img}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_quiet_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_quiet_rd_en", {31'b0, mem_rd_en}, 32'd0);
    end
    push_img(16'h0040, 2, 1);
    d0 = done_cnt;
    do_start(16'h0040, 2, 1);
    wait_done("t6_done_seen", 100, cyc);
    end_checks("t6", d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
